// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sd on clk, deserialises Philips-framed stereo words and
// presents frames on valid/ready. Define I2S_RX_OVERRUN_EN for the sticky overrun flag.
module i2s_rx #(
  parameter int unsigned DW          = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          sck,
  input  logic          ws,
  input  logic          sd,
  output logic [DW-1:0] data_left,
  output logic [DW-1:0] data_right,
  output logic          valid,
`ifdef I2S_RX_OVERRUN_EN
  output logic          overrun,
  input  logic          overrun_clr,
`endif
  input  logic          ready
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StSync, StLeft, StRight} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
  logic                   sck_s, ws_s, sd_s, sck_prev_q, sck_rise;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q, cnt_inc;
  logic [DW-1:0]          shreg_q, word_cur, left_hold_q, frame_l_q, frame_r_q;
  logic                   ws_prev_q, frame_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd};
      sck_prev_q <= sck_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ws_s     = ws_sync_q[SYNC_STAGES-1];
  assign sd_s     = sd_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cnt_inc  = (cnt_q == CW'(DW)) ? cnt_q : cnt_q + CW'(1);

  // Current word with this edge's bit dropped into its left-aligned slot; bits past DW are lost.
  always_comb begin
    word_cur = shreg_q;
    for (int i = 0; i < int'(DW); i++) begin
      if (cnt_q == CW'(DW - 1 - i)) word_cur[i] = sd_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      ws_prev_q    <= 1'b0;
      left_hold_q  <= '0;
      frame_l_q    <= '0;
      frame_r_q    <= '0;
      frame_done_q <= 1'b0;
      data_left    <= '0;
      data_right   <= '0;
      valid        <= 1'b0;
`ifdef I2S_RX_OVERRUN_EN
      overrun      <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (!enable) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        shreg_q   <= '0;
        ws_prev_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StSync;
          // Wait for the end of a right word so the first kept word starts at a left MSB.
          StSync: begin
            if (sck_rise) begin
              ws_prev_q <= ws_s;
              if (ws_prev_q && !ws_s) state_q <= StLeft;
            end
          end
          StLeft, StRight: begin
            if (sck_rise) begin
              ws_prev_q <= ws_s;
              if (ws_s != ws_prev_q) begin
                cnt_q   <= '0;
                shreg_q <= '0;
                if (state_q == StLeft) begin
                  left_hold_q <= word_cur;
                  state_q     <= StRight;
                end else begin
                  frame_l_q    <= left_hold_q;
                  frame_r_q    <= word_cur;
                  frame_done_q <= 1'b1;
                  state_q      <= StLeft;
                end
              end else begin
                shreg_q <= word_cur;
                cnt_q   <= cnt_inc;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // A completing frame may replace one being transferred this cycle; otherwise it is dropped.
      if (frame_done_q && (!valid || ready)) begin
        data_left  <= frame_l_q;
        data_right <= frame_r_q;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
`ifdef I2S_RX_OVERRUN_EN
      if (frame_done_q && valid && !ready) overrun <= 1'b1;
      else if (overrun_clr)                overrun <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver, the receive counterpart of the team's I2S transmitter core.
- Runs on a single system clock and oversamples the external sck/ws/sd pins.
- Deserialises left and right words MSB-first and presents each stereo frame on a valid/ready interface.
- The valid/ready interface feeds a FIFO or Avalon slave register block.

Parameters:
- DW, 16, output sample width per channel in bits.
- SYNC_STAGES, 2, synchroniser flop depth for sck/ws/sd (minimum 2).

Ports:
- clk  input  1  system clock; must be ≥ 4× sck frequency.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  receiver enable.
- sck  input  1  I2S bit clock from the external master, asynchronous to clk.
- ws  input  1  word select: 0 = left, 1 = right.
- sd  input  1  serial data.
- data_left  output  DW  left sample of the presented frame.
- data_right  output  DW  right sample of the presented frame.
- valid  output  1  frame available.
- ready  input  1  consumer accepts the frame.
- overrun  output  1  sticky overrun flag; present only with I2S_RX_OVERRUN_EN.
- overrun_clr  input  1  clears overrun; present only with I2S_RX_OVERRUN_EN.

Behaviour:
- Reset: all state is cleared; state=IDLE; data_left, data_right, valid and overrun = 0.
- Synchronisation and sampling:
  - sck, ws and sd each pass through SYNC_STAGES flops.
  - An sck rising edge is detected as synchronised sck now 1 and previously 0.
  - All sampling happens only in the detect cycle; ws and sd are sampled from the synchronised versions.
- Word framing (Philips I2S, one-bit delay):
  - On each detected edge, sd is shifted into shreg MSB-first and bit counter cnt increments, saturating at DW.
  - Only the first DW bits of a word are kept; extra bits are ignored.
  - If the sampled ws differs from ws_prev (ws at the previous edge), this edge's bit is the LSB of the channel ws_prev, and that word finishes this cycle.
  - Finishing a word: result = shreg left-aligned; if cnt < DW, the LSBs are zero-padded. Then cnt and shreg clear, and the next edge is the MSB of the new channel.
- State machine:
  - IDLE: entered when enable=0; counters cleared. Goes to SYNC when enable=1.
  - SYNC: ignores data until the first ws 1→0 transition (right word ends), then goes to LEFT. This discards partial words.
  - LEFT: on a 0→1 transition, stores the left word in a holding register and goes to RIGHT.
  - RIGHT: on a 1→0 transition, the frame is complete and the state goes to LEFT.
  - enable=0 in any state goes to IDLE on the next clk; a pending frame (valid=1) is kept until accepted.
- Output handshake:
  - On frame completion with valid=0: data_left/data_right load and valid=1 on the next clk.
  - The frame is held stable while valid=1 && ready=0.
  - A transfer occurs on a clk edge with valid && ready; valid then drops unless a new frame loads in the same cycle.
  - Completion in the same cycle as a transfer: the new frame loads and valid stays 1; this is not an overrun.
  - Completion while valid=1 && ready=0: the new frame is dropped and the old frame is kept (overrun event).
- Latency: valid rises SYNC_STAGES+2 clk cycles after the sck rising edge at the pins that carries the right-channel LSB (the edge where ws is first sampled 0).
- Reset mid-word or mid-frame: the partial word is lost; the block returns to IDLE and resynchronises in SYNC.

Optional Feature:
- I2S_RX_OVERRUN_EN:
  - Defined: overrun goes to 1 on the clk after an overrun event and stays set until overrun_clr=1 or reset. If overrun_clr and a new event occur in the same cycle, the set wins.
  - Undefined: overrun and overrun_clr ports are absent; dropped frames are silent.

Test Plan:
- Reset: assert reset_n=0 with sck toggling → data_left=0, data_right=0, valid=0, overrun=0 throughout.
- Basic frame: DW=16, sck=clk/8, send L=0xA5C3 then R=0x1234 with ready=1 → one valid pulse with data_left=0xA5C3, data_right=0x1234, SYNC_STAGES+2 clks after the right-LSB sck edge.
- Alignment: raise enable midway through a left word of 0x1111/0x2222, then send full frame 0xBEEF/0xCAFE → first valid carries 0xBEEF/0xCAFE; the partial frame is never presented.
- Length mismatch: DW=16, send 24-bit words 0xABCDEF/0x123456 → 0xABCD/0x1234; send 8-bit words 0x5A/0xC3 → 0x5A00/0xC300.
- Backpressure: ready=0, send frames 0x0001/0x0002 then 0x0003/0x0004 → valid holds 0x0001/0x0002 and overrun=1. Pulse overrun_clr → overrun=0. Raise ready → exactly one transfer.
- Simultaneous: ready rises in the same clk the next frame completes → old frame transfers, new frame loads, valid stays 1, overrun stays 0.
